// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the single main-memory port between I$ and D$ misses.
// Holds at most one outstanding miss per cache. Grants one at a time; a grant is
// never preempted. It waits LATENCY_REQ cycles, then issues to memory and returns
// the fill or store ack to the owning cache.
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration when both
// caches are pending. Otherwise D$ has fixed priority.
//
// Request info layout: {addr[ADDR_WIDTH-1:0], is_store, data[LINE_WIDTH-1:0]}.
//
// Ports:
//   clk_i, reset_ni                    clock, asynchronous active-low reset
//   icache_req_valid_i/_info_i         I$ miss request pulse and payload
//   dcache_req_valid_i/_info_i         D$ miss request pulse and payload
//   req_mm_valid_o/_info_o             memory request, held until rsp_mm_valid_i
//   rsp_mm_valid_i/_data_i/_bus_error_i  memory response
//   rsp_valid_o, rsp_cache_id_o        one-cycle response pulse, 0 = I$, 1 = D$
//   rsp_data_o, rsp_bus_error_o        returned line (held), error for this response
//   busy_o                             FSM not idle
//   overflow_err_o                     sticky: request arrived while that source was pending
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned LATENCY_REQ = 5,
  localparam int unsigned REQ_WIDTH  = ADDR_WIDTH + 1 + LINE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  icache_req_valid_i,
  input  logic [REQ_WIDTH-1:0]  icache_req_info_i,
  input  logic                  dcache_req_valid_i,
  input  logic [REQ_WIDTH-1:0]  dcache_req_info_i,
  output logic                  req_mm_valid_o,
  output logic [REQ_WIDTH-1:0]  req_mm_info_o,
  input  logic                  rsp_mm_valid_i,
  input  logic [LINE_WIDTH-1:0] rsp_mm_data_i,
  input  logic                  rsp_mm_bus_error_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_cache_id_o,
  output logic [LINE_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_bus_error_o,
  output logic                  busy_o,
  output logic                  overflow_err_o
);

  localparam int unsigned CntWidth = $clog2(LATENCY_REQ) + 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(LATENCY_REQ - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StIssue, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  grant_q, grant_d;
  logic                  grant_sel;
  logic                  pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic [REQ_WIDTH-1:0]  info_i_q, info_d_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  overflow_q, overflow_d;
  logic                  mm_done, clr_i, clr_d, acc_i, acc_d;

  // A response clearing a source in the same cycle it re-requests lets the new request in.
  always_comb begin
    mm_done    = (state_q == StIssue) && rsp_mm_valid_i;
    clr_i      = mm_done && !grant_q;
    clr_d      = mm_done && grant_q;
    acc_i      = icache_req_valid_i && (!pend_i_q || clr_i);
    acc_d      = dcache_req_valid_i && (!pend_d_q || clr_d);
    pend_i_d   = acc_i ? 1'b1 : (clr_i ? 1'b0 : pend_i_q);
    pend_d_d   = acc_d ? 1'b1 : (clr_d ? 1'b0 : pend_d_q);
    overflow_d = overflow_q || (icache_req_valid_i && !acc_i) || (dcache_req_valid_i && !acc_d);
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_comb begin
    grant_sel = pend_d_q;
    if (pend_i_q && pend_d_q) grant_sel = !last_grant_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_grant_q <= 1'b0;
    end else if (state_q == StIdle && (pend_i_q || pend_d_q)) begin
      last_grant_q <= grant_sel;
    end
  end
`else
  // Fixed priority: D$ wins whenever it is pending.
  always_comb grant_sel = pend_d_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (pend_i_q || pend_d_q) begin
          grant_d = grant_sel;
          cnt_d   = '0;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (cnt_q == CntLast) state_d = StIssue;
        else                  cnt_d   = cnt_q + CntWidth'(1);
      end
      StIssue: begin
        if (rsp_mm_valid_i) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      pend_i_q   <= 1'b0;
      pend_d_q   <= 1'b0;
      info_i_q   <= '0;
      info_d_q   <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      pend_i_q   <= pend_i_d;
      pend_d_q   <= pend_d_d;
      overflow_q <= overflow_d;
      if (acc_i) info_i_q <= icache_req_info_i;
      if (acc_d) info_d_q <= dcache_req_info_i;
      if (mm_done) begin
        data_q <= rsp_mm_data_i;
        err_q  <= rsp_mm_bus_error_i;
      end
    end
  end

  // The granted source stays pending until its response, so its info register cannot
  // change while the request is on the memory port.
  always_comb begin
    req_mm_valid_o  = (state_q == StIssue);
    req_mm_info_o   = '0;
    if (req_mm_valid_o) req_mm_info_o = grant_q ? info_d_q : info_i_q;
    rsp_valid_o     = (state_q == StResp);
    rsp_cache_id_o  = rsp_valid_o && grant_q;
    rsp_bus_error_o = rsp_valid_o && err_q;
    rsp_data_o      = data_q;
    busy_o          = (state_q != StIdle);
    overflow_err_o  = overflow_q;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 32;
  localparam int unsigned LAT = 5;
  localparam int unsigned RW = AW + 1 + LW;
  localparam logic [AW-1:0] MemDepth = 16'h8000;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          icache_req_valid, dcache_req_valid;
  logic [RW-1:0] icache_req_info, dcache_req_info;
  logic          req_mm_valid;
  logic [RW-1:0] req_mm_info;
  logic          rsp_mm_valid;
  logic [LW-1:0] rsp_mm_data;
  logic          rsp_mm_bus_error;
  logic          rsp_valid, rsp_cache_id, rsp_bus_error, busy, overflow_err;
  logic [LW-1:0] rsp_data;

  int total = 0;
  int bad   = 0;

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY_REQ(LAT)) dut (
    .clk_i              (clk),
    .reset_ni           (reset_ni),
    .icache_req_valid_i (icache_req_valid),
    .icache_req_info_i  (icache_req_info),
    .dcache_req_valid_i (dcache_req_valid),
    .dcache_req_info_i  (dcache_req_info),
    .req_mm_valid_o     (req_mm_valid),
    .req_mm_info_o      (req_mm_info),
    .rsp_mm_valid_i     (rsp_mm_valid),
    .rsp_mm_data_i      (rsp_mm_data),
    .rsp_mm_bus_error_i (rsp_mm_bus_error),
    .rsp_valid_o        (rsp_valid),
    .rsp_cache_id_o     (rsp_cache_id),
    .rsp_data_o         (rsp_data),
    .rsp_bus_error_o    (rsp_bus_error),
    .busy_o             (busy),
    .overflow_err_o     (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [RW-1:0] mk_info(input logic [AW-1:0] a, input logic st);
    return {a, st, 16'hdead, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset_ni = 1'b0;
    icache_req_valid = 0; dcache_req_valid = 0;
    icache_req_info = '0; dcache_req_info = '0;
    rsp_mm_valid = 0; rsp_mm_data = '0; rsp_mm_bus_error = 0;
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; drives the pulse for exactly one cycle.
  task automatic pulse(input bit iv, input bit dv, input logic [AW-1:0] ia,
                       input logic [AW-1:0] da, input bit st);
    icache_req_valid = iv; icache_req_info = mk_info(ia, st);
    dcache_req_valid = dv; dcache_req_info = mk_info(da, st);
    @(negedge clk);
    icache_req_valid = 0; dcache_req_valid = 0;
  endtask

  task automatic wait_issue(input string tag, input logic [AW-1:0] exp_addr);
    int n = 0;
    while (!req_mm_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " issue"}, req_mm_valid, 1);
    chk({tag, " addr"}, req_mm_info[RW-1 -: AW], exp_addr);
  endtask

  // Memory answers lat cycles after the request appeared, then the response is checked.
  task automatic finish_rsp(input string tag, input int lat, input bit exp_id,
                            input logic [AW-1:0] exp_addr, input bit exp_err,
                            input bit rep_i, input bit rep_d,
                            input logic [AW-1:0] ria, input logic [AW-1:0] rda);
    logic [RW-1:0] held = req_mm_info;
    logic [AW-1:0] a;
    bit stable = 1;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (!req_mm_valid || req_mm_info !== held) stable = 0;
    end
    chk({tag, " held"}, stable, 1);
    a = req_mm_info[RW-1 -: AW];
    rsp_mm_valid = 1; rsp_mm_data = mem_line(a); rsp_mm_bus_error = (a >= MemDepth);
    @(negedge clk);
    rsp_mm_valid = 0; rsp_mm_data = '0; rsp_mm_bus_error = 0;
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " id"}, rsp_cache_id, exp_id);
    chk({tag, " data"}, rsp_data, mem_line(exp_addr));
    chk({tag, " err"}, rsp_bus_error, exp_err);
    chk({tag, " req_drop"}, req_mm_valid, 0);
    icache_req_valid = rep_i; icache_req_info = mk_info(ria, 1'b0);
    dcache_req_valid = rep_d; dcache_req_info = mk_info(rda, 1'b0);
    @(negedge clk);
    icache_req_valid = 0; dcache_req_valid = 0;
    chk({tag, " one_pulse"}, rsp_valid, 0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (req_mm_valid || rsp_valid || busy) seen = 1;
    end
    chk(tag, seen, 0);
  endtask

  typedef struct {
    bit iv; bit dv; logic [AW-1:0] ia; logic [AW-1:0] da; bit st;
    int lat; int nrsp; bit id0; bit err0; bit err1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    bit exp_id;
    logic [AW-1:0] ea;

    vecs[0] = '{1, 0, 16'h1000, 16'h0000, 0, 3, 1, 0, 0, 0};
    vecs[1] = '{0, 1, 16'h0000, 16'h2040, 0, 1, 1, 1, 0, 0};
    vecs[2] = '{1, 1, 16'h0100, 16'h0200, 0, 2, 2, 1, 0, 0};
    vecs[3] = '{0, 1, 16'h0000, 16'h9000, 0, 2, 1, 1, 1, 0};
    vecs[4] = '{1, 0, 16'h0040, 16'h0000, 1, 4, 1, 0, 0, 0};
    vecs[5] = '{1, 1, 16'hA000, 16'h0300, 0, 1, 2, 1, 0, 1};

    reset_dut();
    chk("reset outs", {req_mm_valid, rsp_valid, rsp_cache_id, rsp_bus_error, busy,
                       overflow_err}, 0);
    chk("reset data", rsp_data, 0);

    // Issue latency: request visible 7 cycles after the pulse cycle.
    icache_req_valid = 1; icache_req_info = mk_info(16'h1000, 0);
    k = 0;
    do begin
      @(negedge clk);
      icache_req_valid = 0;
      k++;
    end while (!req_mm_valid && k < 40);
    chk("latency", k, 7);
    wait_issue("lat", 16'h1000);
    finish_rsp("lat", 3, 0, 16'h1000, 0, 0, 0, 0, 0);

    // Vector table (reset before each, so last_grant starts at I$ in RR mode too).
    for (int v = 0; v < 6; v++) begin
      reset_dut();
      pulse(vecs[v].iv, vecs[v].dv, vecs[v].ia, vecs[v].da, vecs[v].st);
      for (int r = 0; r < vecs[v].nrsp; r++) begin
        exp_id = (r == 0) ? vecs[v].id0 : !vecs[v].id0;
        ea = exp_id ? vecs[v].da : vecs[v].ia;
        wait_issue($sformatf("vec%0d.%0d", v, r), ea);
        finish_rsp($sformatf("vec%0d.%0d", v, r), vecs[v].lat, exp_id, ea,
                   (r == 0) ? vecs[v].err0 : vecs[v].err1, 0, 0, 0, 0);
      end
      watch_quiet($sformatf("vec%0d quiet", v), 12);
    end

    // D$ arrives while I$ is on the memory port: no preemption.
    reset_dut();
    pulse(1, 0, 16'h1234, 0, 0);
    wait_issue("nopre I", 16'h1234);
    pulse(0, 1, 0, 16'h0400, 0);
    chk("nopre still I", req_mm_info[RW-1 -: AW], 16'h1234);
    finish_rsp("nopre I", 3, 0, 16'h1234, 0, 0, 0, 0, 0);
    wait_issue("nopre D", 16'h0400);
    finish_rsp("nopre D", 2, 1, 16'h0400, 0, 0, 0, 0, 0);

    // Both re-request after every response.
    reset_dut();
    pulse(1, 1, 16'h0500, 16'h0600, 0);
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = (r % 2 == 0);
`else
      exp_id = 1;
`endif
      ea = exp_id ? 16'h0600 : 16'h0500;
      wait_issue($sformatf("arb%0d", r), ea);
      finish_rsp($sformatf("arb%0d", r), 1, exp_id, ea, 0, !exp_id, exp_id, 16'h0500,
                 16'h0600);
    end

    // Overflow: second I$ pulse while pending is dropped and flagged.
    reset_dut();
    icache_req_valid = 1; icache_req_info = mk_info(16'h0700, 0);
    @(negedge clk);
    chk("ovf before", overflow_err, 0);
    icache_req_info = mk_info(16'h0800, 0);
    @(negedge clk);
    icache_req_valid = 0;
    chk("ovf set", overflow_err, 1);
    wait_issue("ovf", 16'h0700);
    finish_rsp("ovf", 2, 0, 16'h0700, 0, 0, 0, 0, 0);
    watch_quiet("ovf single rsp", 15);
    chk("ovf sticky", overflow_err, 1);

    // Reset during DELAY.
    reset_dut();
    pulse(1, 0, 16'h0900, 0, 0);
    repeat (2) @(negedge clk);
    chk("rstD busy", busy, 1);
    reset_ni = 0;
    #1;
    chk("rstD outs", |{req_mm_valid, req_mm_info, rsp_valid, rsp_cache_id, rsp_bus_error,
                       busy, overflow_err, rsp_data}, 0);
    @(negedge clk);
    reset_ni = 1;
    watch_quiet("rstD quiet", 30);

    // Reset during ISSUE, after a response left non-zero data behind.
    pulse(1, 0, 16'h0a00, 0, 0);
    wait_issue("rstI pre", 16'h0a00);
    finish_rsp("rstI pre", 1, 0, 16'h0a00, 0, 0, 0, 0, 0);
    pulse(1, 0, 16'h0b00, 0, 0);
    wait_issue("rstI", 16'h0b00);
    reset_ni = 0;
    #1;
    chk("rstI outs", |{req_mm_valid, req_mm_info, rsp_valid, rsp_cache_id, rsp_bus_error,
                       busy, rsp_data}, 0);
    @(negedge clk);
    reset_ni = 1;
    watch_quiet("rstI quiet", 30);

    // Stray memory response while idle is ignored.
    rsp_mm_valid = 1; rsp_mm_data = 32'hffff_ffff;
    @(negedge clk);
    rsp_mm_valid = 0;
    chk("stray rsp", {rsp_valid, busy}, 0);
    chk("stray data", rsp_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
